ddr3_app_traffic_gen: RTL
=========================

Name: ddr3_app_traffic_gen

Overview:
- Parametrised traffic generator and checker for the MIG 7-series DDR3 user (app_*) interface.
- Replaces the tied-off app_* registers in the board top; sits between the top and the MIG core, on the MIG ui_clk.
- Writes a deterministic pattern over a configurable address window, reads it back and compares, then repeats.
- Reports pass count, error count, first failing address and the tg_compare_error / LED status.

Parameters:
ADDR_WIDTH, 28, app_addr width
DATA_WIDTH, 128, app data width (multiple of 32)
START_ADDR, 28'h0, first burst address
NUM_BURSTS, 1024, bursts per pass (>=1); burst address step is fixed at 8
MAX_OUTSTANDING, 16, maximum read commands issued but not yet returned (power of 2, <=64)
PATTERN_MODE, 0, 0 = address-as-data, 1 = walking one, 2 = address XOR pass-parity inversion
LOOP, 1, 1 = repeat passes forever, 0 = stop after one pass

Ports:
i_clk  in  1  MIG ui_clk
i_rst  in  1  asynchronous active-high reset (MIG ui_clk_sync_rst)
i_calib_done  in  1  MIG init_calib_complete
i_start  in  1  one-cycle pulse; starts a run from IDLE
o_app_addr  out  ADDR_WIDTH  command address
o_app_cmd  out  3  3'b000 write, 3'b001 read
o_app_en  out  1  command valid
i_app_rdy  in  1  command accepted when o_app_en && i_app_rdy
o_app_wdf_data  out  DATA_WIDTH  write data
o_app_wdf_wren  out  1  write data valid
o_app_wdf_end  out  1  equals o_app_wdf_wren (one beat per burst)
o_app_wdf_mask  out  DATA_WIDTH/8  constant 0
i_app_wdf_rdy  in  1  data accepted when o_app_wdf_wren && i_app_wdf_rdy
i_app_rd_data  in  DATA_WIDTH  read data
i_app_rd_data_valid  in  1  read data valid (in-order return)
o_busy  out  1  run in progress
o_error  out  1  sticky mismatch flag (drives tg_compare_error)
o_err_count  out  16  mismatching beats, saturates at 16'hFFFF
o_pass_count  out  32  completed error-free or errored passes, wraps
o_first_err_addr  out  ADDR_WIDTH  address of the first mismatch

Behaviour:
- Reset: all outputs 0, state IDLE, o_app_cmd = 3'b000.
- States: IDLE -> WAIT_CAL (on i_start) -> WRITE -> READ -> DRAIN -> (LOOP ? WRITE : IDLE).
- WAIT_CAL exits on the first cycle i_calib_done = 1.
- i_start is ignored outside IDLE.
- o_busy = 1 in every state except IDLE.
- WRITE: o_app_en and o_app_wdf_wren are asserted together for the burst at address A.
  - Each is held, with its addr/cmd/data stable, until its own handshake completes; each then deasserts independently.
  - The next burst starts the cycle after both handshakes complete (same-cycle completion allowed).
  - After burst NUM_BURSTS-1: go to READ.
- READ: o_app_en with cmd 3'b001 is issued back-to-back.
  - Addresses advance on each accept.
  - o_app_en is deasserted while outstanding == MAX_OUTSTANDING.
  - outstanding increments on accept and decrements on i_app_rd_data_valid; both in the same cycle leaves it unchanged.
  - After the last read is accepted: go to DRAIN.
- DRAIN: wait until outstanding == 0 and all NUM_BURSTS beats are compared, then increment o_pass_count and take the LOOP branch.
- Check: an independent expected-address counter advances on every i_app_rd_data_valid.
  - Expected data = pattern(address, pass parity).
  - On mismatch: o_error <= 1, o_err_count += 1 (saturating).
  - o_first_err_addr is latched only while o_error was 0.
  - Read data arriving in any state other than READ/DRAIN is ignored.
- Patterns, with idx = (A - START_ADDR) >> 3:
  - Mode 0: {DATA_WIDTH/32{A zero-extended to 32 bits}}.
  - Mode 1: bit (idx mod DATA_WIDTH) set.
  - Mode 2: mode 0 data, inverted on odd passes.
- Address arithmetic is ADDR_WIDTH-bit, modulo 2^ADDR_WIDTH.
- Error counters are never cleared by a new pass; only i_rst clears them.
- i_calib_done falling mid-run: no effect on the FSM.
- Reset mid-transaction: everything drops asynchronously to the reset values.

Decomposition:
- Package ddr3_tg_pkg holds:
  - command constants CMD_WRITE = 3'b000 and CMD_READ = 3'b001
  - the state enum
  - pattern mode constants
  - BURST_STEP = 8
- Sub-module ddr3_tg_pattern: combinational (address, pass parity, mode) -> data.
  - Instantiated twice: once for write data, once for expected data.

Test Plan:
- Ideal MIG model (rdy always 1, read latency 20): NUM_BURSTS = 16, mode 0, LOOP = 0 -> 16 writes then 16 reads; o_pass_count = 1, o_error = 0, o_busy falls after the last compare.
- Random i_app_rdy / i_app_wdf_rdy stalls (50%), including cmd accepted several cycles before data and vice versa -> each address written exactly once, no data change while stalled, no errors.
- MAX_OUTSTANDING = 4 with read latency 40 -> o_app_en never asserted while 4 reads are pending; all reads complete.
- Model corrupts bit 0 of the beat at address 28'h40 -> o_error = 1, o_err_count = 1, o_first_err_addr = 28'h40; a second corruption at 28'h80 leaves o_first_err_addr unchanged.
- Mode 2, LOOP = 1 -> second pass writes inverted data; model returns stored data; o_pass_count reaches 3 with o_error = 0.
- i_calib_done held 0 for 500 cycles after i_start -> no app_en; assert i_rst mid-WRITE -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/ddr3_tg_pkg.sv
// Shared constants and types for the DDR3 app-interface traffic generator.
package ddr3_tg_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef logic [2:0] tg_state_t;

    localparam tg_state_t ST_IDLE     = 3'd0;
    localparam tg_state_t ST_WAIT_CAL = 3'd1;
    localparam tg_state_t ST_WRITE    = 3'd2;
    localparam tg_state_t ST_READ     = 3'd3;
    localparam tg_state_t ST_DRAIN    = 3'd4;

    localparam logic [1:0] PAT_ADDR     = 2'd0;
    localparam logic [1:0] PAT_WALK1    = 2'd1;
    localparam logic [1:0] PAT_ADDR_INV = 2'd2;

    localparam int BURST_STEP = 8;

endpackage

// File: rtl/ddr3_app_traffic_gen_if.sv
// MIG 7-series app_* command, write-data and read-data bundle.
interface ddr3_app_traffic_gen_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0]   o_app_addr;
    logic [2:0]              o_app_cmd;
    logic                    o_app_en;
    logic                    i_app_rdy;
    logic [DATA_WIDTH-1:0]   o_app_wdf_data;
    logic                    o_app_wdf_wren;
    logic                    o_app_wdf_end;
    logic [DATA_WIDTH/8-1:0] o_app_wdf_mask;
    logic                    i_app_wdf_rdy;
    logic [DATA_WIDTH-1:0]   i_app_rd_data;
    logic                    i_app_rd_data_valid;

    modport master (
        output o_app_addr, o_app_cmd, o_app_en,
        output o_app_wdf_data, o_app_wdf_wren,
        output o_app_wdf_end, o_app_wdf_mask,
        input  i_app_rdy, i_app_wdf_rdy,
        input  i_app_rd_data, i_app_rd_data_valid
    );

    modport slave (
        input  o_app_addr, o_app_cmd, o_app_en,
        input  o_app_wdf_data, o_app_wdf_wren,
        input  o_app_wdf_end, o_app_wdf_mask,
        output i_app_rdy, i_app_wdf_rdy,
        output i_app_rd_data, i_app_rd_data_valid
    );
endinterface

// File: rtl/ddr3_tg_pattern.sv
// Combinational data pattern for one burst address and pass parity.
module ddr3_tg_pattern
    import ddr3_tg_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 28,
    parameter int                    DATA_WIDTH = 128,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  parity,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] data
);
    localparam int SH = $clog2(BURST_STEP);
    localparam logic [ADDR_WIDTH-1:0] DW_A = ADDR_WIDTH'(DATA_WIDTH);

    logic [31:0]           a32;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] pos;
    logic [DATA_WIDTH-1:0] rep;
    logic [DATA_WIDTH-1:0] walk;

    always_comb begin
        a32  = 32'(addr);
        idx  = (addr - START_ADDR) >> SH;
        pos  = idx % DW_A;
        rep  = {(DATA_WIDTH/32){a32}};
        walk = DATA_WIDTH'(1) << pos;
        case (mode)
            PAT_ADDR:     data = rep;
            PAT_WALK1:    data = walk;
            PAT_ADDR_INV: data = rep ^ {DATA_WIDTH{parity}};
            default:      data = '0;
        endcase
    end

endmodule

// File: rtl/ddr3_app_traffic_gen.sv
// Write/read-back/compare traffic generator for the MIG DDR3 app interface.
module ddr3_app_traffic_gen
    import ddr3_tg_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 28,
    parameter int                    DATA_WIDTH      = 128,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR      = '0,
    parameter int                    NUM_BURSTS      = 1024,
    parameter int                    MAX_OUTSTANDING = 16,
    parameter int                    PATTERN_MODE    = 0,
    parameter int                    LOOP            = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_calib_done,
    input  logic                  i_start,
    ddr3_app_traffic_gen_if.master app,
    output logic                  o_busy,
    output logic                  o_error,
    output logic [15:0]           o_err_count,
    output logic [31:0]           o_pass_count,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr
);
    localparam int CW = $clog2(NUM_BURSTS + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_BURSTS - 1);
    localparam logic [CW-1:0] NB   = CW'(NUM_BURSTS);
    localparam logic [OW-1:0] MAXO = OW'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_STEP);
    localparam logic [1:0] MODE = 2'(PATTERN_MODE);

    tg_state_t             state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CW-1:0]         cnt;
    logic                  cmd_pend;
    logic                  dat_pend;
    logic [OW-1:0]         outs;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [CW-1:0]         cmp_cnt;

    logic                  in_wr, in_rd, app_en, wren;
    logic                  cmd_acc, dat_acc, burst_done;
    logic                  rd_ok, mismatch, drain_done, pass_start;
    logic [DATA_WIDTH-1:0] wr_data, exp_data;

    ddr3_tg_pattern #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .START_ADDR(START_ADDR)
    ) u_wr_pat (
        .addr(addr), .parity(o_pass_count[0]),
        .mode(MODE), .data(wr_data)
    );

    ddr3_tg_pattern #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .START_ADDR(START_ADDR)
    ) u_exp_pat (
        .addr(exp_addr), .parity(o_pass_count[0]),
        .mode(MODE), .data(exp_data)
    );

    always_comb begin
        in_wr      = (state == ST_WRITE);
        in_rd      = (state == ST_READ);
        app_en     = (in_wr & cmd_pend) | (in_rd & (outs != MAXO));
        wren       = in_wr & dat_pend;
        cmd_acc    = app_en & app.i_app_rdy;
        dat_acc    = wren & app.i_app_wdf_rdy;
        burst_done = in_wr & (~cmd_pend | cmd_acc)
                   & (~dat_pend | dat_acc);
        rd_ok      = app.i_app_rd_data_valid
                   & (in_rd | (state == ST_DRAIN));
        mismatch   = rd_ok & (app.i_app_rd_data != exp_data);
        drain_done = (state == ST_DRAIN) & (outs == '0)
                   & (cmp_cnt == NB);
        pass_start = ((state == ST_WAIT_CAL) & i_calib_done)
                   | (drain_done & (LOOP != 0));
    end

    assign app.o_app_addr     = addr;
    assign app.o_app_cmd      = in_rd ? CMD_READ : CMD_WRITE;
    assign app.o_app_en       = app_en;
    assign app.o_app_wdf_data = wren ? wr_data : '0;
    assign app.o_app_wdf_wren = wren;
    assign app.o_app_wdf_end  = wren;
    assign app.o_app_wdf_mask = '0;
    assign o_busy             = (state != ST_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            addr             <= '0;
            cnt              <= '0;
            cmd_pend         <= 1'b0;
            dat_pend         <= 1'b0;
            outs             <= '0;
            exp_addr         <= '0;
            cmp_cnt          <= '0;
            o_error          <= 1'b0;
            o_err_count      <= '0;
            o_pass_count     <= '0;
            o_first_err_addr <= '0;
        end else begin
            if (in_rd & cmd_acc & ~rd_ok)
                outs <= outs + OW'(1);
            else if (rd_ok & ~(in_rd & cmd_acc) & (outs != '0))
                outs <= outs - OW'(1);

            if (rd_ok) begin
                exp_addr <= exp_addr + STEP;
                cmp_cnt  <= cmp_cnt + CW'(1);
            end
            if (mismatch) begin
                o_error <= 1'b1;
                if (o_err_count != 16'hFFFF)
                    o_err_count <= o_err_count + 16'd1;
                if (!o_error)
                    o_first_err_addr <= exp_addr;
            end

            unique case (state)
                ST_IDLE: begin
                    if (i_start)
                        state <= ST_WAIT_CAL;
                end
                ST_WAIT_CAL: ;
                ST_WRITE: begin
                    if (cmd_acc)
                        cmd_pend <= 1'b0;
                    if (dat_acc)
                        dat_pend <= 1'b0;
                    if (burst_done) begin
                        if (cnt == LAST) begin
                            state <= ST_READ;
                            addr  <= START_ADDR;
                            cnt   <= '0;
                        end else begin
                            addr     <= addr + STEP;
                            cnt      <= cnt + CW'(1);
                            cmd_pend <= 1'b1;
                            dat_pend <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (cmd_acc) begin
                        if (cnt == LAST) begin
                            state <= ST_DRAIN;
                        end else begin
                            addr <= addr + STEP;
                            cnt  <= cnt + CW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        o_pass_count <= o_pass_count + 32'd1;
                        if (LOOP == 0)
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A new pass restarts every per-pass counter; error state is kept.
            if (pass_start) begin
                state    <= ST_WRITE;
                addr     <= START_ADDR;
                cnt      <= '0;
                cmd_pend <= 1'b1;
                dat_pend <= 1'b1;
                exp_addr <= START_ADDR;
                cmp_cnt  <= '0;
            end
        end
    end

endmodule
